// File: rtl/ram2_ctrl.sv
// RAM2 SRAM initiator: turns single-cycle MEM-stage load/store requests into timed strobe sequences.
// Optional feature macro RAM2_WAITSTATE_EN stretches RD and WR_PULSE by WAIT_CYCLES cycles.
module ram2_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              stall_req,
  output logic [ADDR_W-1:0] ram2_addr,
  inout  wire  [DATA_W-1:0] ram2_data,
  output logic              ram2_en_n,
  output logic              ram2_oe_n,
  output logic              ram2_we_n
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ram2_addr_q, ram2_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              en_n_q, en_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              drive_q, drive_d;
  logic              req;
  logic              wait_done;
  logic              unused_addr_bits;

  assign req              = mem_ce & (mem_re | mem_we);
  assign unused_addr_bits = ^mem_addr_i[31:ADDR_W];

`ifdef RAM2_WAITSTATE_EN
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wait_done = (cnt_q == '0);

  // Down-counter reloaded whenever RD or WR_PULSE is entered, so the strobe lasts 1+WAIT_CYCLES cycles
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) && ((state_d == RD) || (state_d == WR_PULSE))) begin
      cnt_d = CNT_W'(WAIT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign wait_done = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    ram2_addr_d = ram2_addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        ram2_addr_d = '0;
        if (req) begin
          ram2_addr_d = mem_addr_i[ADDR_W-1:0];
          wdata_d     = mem_data_i;
          state_d     = mem_we ? WR_SETUP : RD;
        end
      end
      RD: begin
        if (wait_done) begin
          rdata_d = ram2_data;
          state_d = DONE;
        end
      end
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: begin
        if (wait_done) begin
          state_d = WR_HOLD;
        end
      end
      WR_HOLD:  state_d = DONE;
      DONE: begin
        state_d     = IDLE;
        ram2_addr_d = '0;
      end
      default: begin
        state_d     = IDLE;
        ram2_addr_d = '0;
      end
    endcase
  end

  // Strobes are registered from the next state so they switch cleanly with the state itself
  always_comb begin
    en_n_d  = (state_d == IDLE) || (state_d == DONE);
    oe_n_d  = (state_d != RD);
    we_n_d  = (state_d != WR_PULSE);
    drive_d = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ram2_addr_q <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      en_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      drive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram2_addr_q <= ram2_addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      en_n_q      <= en_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      drive_q     <= drive_d;
    end
  end

  assign stall_req  = ((state_q == IDLE) && req) || (state_q == RD) ||
                      (state_q == WR_SETUP) || (state_q == WR_PULSE) || (state_q == WR_HOLD);
  assign mem_data_o = rdata_q;
  assign ram2_addr  = ram2_addr_q;
  assign ram2_en_n  = en_n_q;
  assign ram2_oe_n  = oe_n_q;
  assign ram2_we_n  = we_n_q;
  assign ram2_data  = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram2_ctrl.sv
// Directed bench for ram2_ctrl with a small behavioural SRAM on the bidirectional bus.
// Expected timings account for RAM2_WAITSTATE_EN with WAIT_CYCLES=2 when that macro is defined.
module tb_ram2_ctrl;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;
`ifdef RAM2_WAITSTATE_EN
  localparam int WAIT = 2;
`else
  localparam int WAIT = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_ce;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_addr_i;
  logic [DATA_W-1:0] mem_data_i;
  logic [DATA_W-1:0] mem_data_o;
  logic              stall_req;
  logic [ADDR_W-1:0] ram2_addr;
  wire  [DATA_W-1:0] ram2_data;
  logic              ram2_en_n;
  logic              ram2_oe_n;
  logic              ram2_we_n;

  int error_count = 0;
  int check_count = 0;
  int cycle = 0;

  ram2_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .WAIT_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_ce(mem_ce),
    .mem_re(mem_re),
    .mem_we(mem_we),
    .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i),
    .mem_data_o(mem_data_o),
    .stall_req(stall_req),
    .ram2_addr(ram2_addr),
    .ram2_data(ram2_data),
    .ram2_en_n(ram2_en_n),
    .ram2_oe_n(ram2_oe_n),
    .ram2_we_n(ram2_we_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural SRAM: drives the bus while output-enabled, stores while write-enabled
  logic [31:0] sram [0:255];

  assign ram2_data = (!ram2_en_n && !ram2_oe_n) ? sram[ram2_addr[7:0]] : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (rst) begin
      sram[8'h10] <= 32'h1234_5678;
    end else if (!ram2_en_n && !ram2_we_n) begin
      sram[ram2_addr[7:0]] <= ram2_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Issues one request from the next IDLE cycle and holds it until DONE, counting strobe cycles
  task automatic applyStimulus(input logic re, input logic we, input logic [31:0] addr,
                               input logic [31:0] data, output int stall_n, output int oe_low,
                               output int we_low, output int drive_n, output logic [31:0] rdata,
                               output logic [31:0] addr_idle, output logic [31:0] addr_busy,
                               output int start_cyc, output int done_cyc);
    bit done;
    int i;
    @(negedge clk);
    mem_ce     = 1'b1;
    mem_re     = re;
    mem_we     = we;
    mem_addr_i = addr;
    mem_data_i = data;
    stall_n = 0; oe_low = 0; we_low = 0; drive_n = 0;
    addr_idle = '0; addr_busy = '0;
    done = 1'b0;
    i = 0;
    #1;
    start_cyc = cycle;
    done_cyc  = cycle;
    while (!done && i < 20) begin
      if (stall_req) stall_n++;
      if (!ram2_oe_n) oe_low++;
      if (!ram2_we_n) we_low++;
      if (we && ram2_data === data) drive_n++;
      if (i == 0) addr_idle = 32'(ram2_addr);
      if (i == 1) addr_busy = 32'(ram2_addr);
      if (!stall_req) begin
        done     = 1'b1;
        done_cyc = cycle;
      end else begin
        @(negedge clk);
        #1;
        i++;
      end
    end
    if (!done) checkOutput("access_timeout", 32'd1, 32'd0);
    rdata  = mem_data_o;
    mem_ce = 1'b0;
    mem_re = 1'b0;
    mem_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s, o, w, d, t0, t1, t2, t3;
    logic [31:0] rd, ai, ab;
    mem_ce = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
    mem_addr_i = '0; mem_data_i = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_en_n", 32'(ram2_en_n), 32'd1);
    checkOutput("rst_oe_n", 32'(ram2_oe_n), 32'd1);
    checkOutput("rst_we_n", 32'(ram2_we_n), 32'd1);
    checkOutput("rst_stall", 32'(stall_req), 32'd0);
    checkOutput("rst_addr", 32'(ram2_addr), 32'd0);
    checkOutput("rst_dout", mem_data_o, 32'd0);
    rst = 1'b0;

    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, s, o, w, d, rd, ai, ab, t0, t1);
    checkOutput("ld_stall", 32'(s), 32'(2 + WAIT));
    checkOutput("ld_oe_low", 32'(o), 32'(1 + WAIT));
    checkOutput("ld_we_low", 32'(w), 32'd0);
    checkOutput("ld_addr_idle", ai, 32'd0);
    checkOutput("ld_addr_busy", ab, 32'h10);
    checkOutput("ld_data", rd, 32'h1234_5678);

    // Asynchronous reset in the middle of a read
    @(negedge clk);
    mem_ce = 1'b1; mem_re = 1'b1; mem_we = 1'b0; mem_addr_i = 32'h10;
    @(negedge clk);
    #1;
    checkOutput("mid_rd_oe_n", 32'(ram2_oe_n), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_en_n", 32'(ram2_en_n), 32'd1);
    checkOutput("mid_rst_oe_n", 32'(ram2_oe_n), 32'd1);
    checkOutput("mid_rst_we_n", 32'(ram2_we_n), 32'd1);
    checkOutput("mid_rst_addr", 32'(ram2_addr), 32'd0);
    checkOutput("mid_rst_dout", mem_data_o, 32'd0);
    mem_ce = 1'b0; mem_re = 1'b0;
    #1;
    checkOutput("mid_rst_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, s, o, w, d, rd, ai, ab, t0, t1);
    checkOutput("post_rst_ld_stall", 32'(s), 32'(2 + WAIT));
    checkOutput("post_rst_ld_data", rd, 32'h1234_5678);

    applyStimulus(1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, s, o, w, d, rd, ai, ab, t0, t1);
    checkOutput("st_stall", 32'(s), 32'(4 + WAIT));
    checkOutput("st_we_low", 32'(w), 32'(1 + WAIT));
    checkOutput("st_oe_low", 32'(o), 32'd0);
    checkOutput("st_bus_driven", 32'(d), 32'(3 + WAIT));
    checkOutput("st_addr_busy", ab, 32'h20);
    checkOutput("st_dout_kept", rd, 32'h1234_5678);

    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, s, o, w, d, rd, ai, ab, t0, t1);
    checkOutput("ld20_data", rd, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 1'b1, 32'h30, 32'hCAFE_F00D, s, o, w, d, rd, ai, ab, t0, t1);
    checkOutput("rw_stall", 32'(s), 32'(4 + WAIT));
    checkOutput("rw_oe_low", 32'(o), 32'd0);
    checkOutput("rw_we_low", 32'(w), 32'(1 + WAIT));
    checkOutput("rw_dout_kept", rd, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, s, o, w, d, rd, ai, ab, t0, t1);
    checkOutput("ld30_data", rd, 32'hCAFE_F00D);

    // Back-to-back store then load; the load is presented in the cycle right after DONE
    applyStimulus(1'b0, 1'b1, 32'h40, 32'h0BAD_F00D, s, o, w, d, rd, ai, ab, t0, t1);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, s, o, w, d, rd, ai, ab, t2, t3);
    checkOutput("b2b_gap", 32'(t2 - t1), 32'd1);
    checkOutput("b2b_total", 32'(t3 - t0 + 1), 32'(8 + 2 * WAIT));
    checkOutput("b2b_data", rd, 32'h0BAD_F00D);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
